// File: rtl/gb_pixel_fifo_pkg.sv
// gb_ppu_pkg: PPU-wide types and constants shared by the pixel FIFO files.
package gb_ppu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DISCARD = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } pix_state_e;

    localparam int LCD_W     = 160;
    localparam int PIX_W_CGB = 15;
    localparam int GROUP_PIX = 8;

endpackage

// File: rtl/gb_pixel_fifo_if.sv
// gb_pixel_fifo_if: fetcher push handshake, line control and LCD pixel strobe.
// master = fetcher/LCD side, slave = the pixel FIFO.
interface gb_pixel_fifo_if #(
    parameter int PIX_W = 15
);
    logic               line_start;
    logic [2:0]         scx_fine;
    logic               push;
    logic [8*PIX_W-1:0] push_pix;
    logic               push_ready;
    logic               stall;
    logic [PIX_W-1:0]   lcd_data;
    logic               lcd_clkena;
    logic               line_done;
    logic               busy;

    modport master (
        output line_start, scx_fine, push, push_pix, stall,
        input  push_ready, lcd_data, lcd_clkena, line_done, busy
    );

    modport slave (
        input  line_start, scx_fine, push, push_pix, stall,
        output push_ready, lcd_data, lcd_clkena, line_done, busy
    );
endinterface

// File: rtl/gb_pixel_fifo_mem.sv
// gb_pixel_fifo_mem: DEPTH x PIX_W circular store, 8-wide write, 1-wide read.
// Pointers carry one extra bit so count distinguishes full from empty.
module gb_pixel_fifo_mem import gb_ppu_pkg::*; #(
    parameter int PIX_W = PIX_W_CGB,
    parameter int DEPTH = 16
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [GROUP_PIX*PIX_W-1:0]   wr_pix,
    input  logic                         rd_en,
    output logic [PIX_W-1:0]             rd_pix,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] PTR_STEP = (AW+1)'(GROUP_PIX);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointer update; a clear overrides any same-cycle push or pop.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_STEP;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write: eight consecutive entries starting at the write pointer.
    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            for (int i = 0; i < GROUP_PIX; i++)
                mem[wr_ptr[AW-1:0] + AW'(i)] <= wr_pix[i*PIX_W +: PIX_W];
        end
    end

    assign rd_pix = mem[rd_ptr[AW-1:0]];
    assign count  = wr_ptr - rd_ptr;

endmodule

// File: rtl/gb_pixel_fifo.sv
// gb_pixel_fifo: background/window pixel FIFO between the tile fetcher and the LCD.
// Drops SCX[2:0] leading pixels, honours sprite stalls, emits LINE_PIX pixels per line.
// Optional macro GB_PIXFIFO_STATS_EN adds the underflow_cnt output.
module gb_pixel_fifo import gb_ppu_pkg::*; #(
    parameter int PIX_W    = PIX_W_CGB,
    parameter int DEPTH    = 16,
    parameter int LINE_PIX = LCD_W
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce_cpu,
`ifdef GB_PIXFIFO_STATS_EN
    output logic [15:0]   underflow_cnt,
`endif
    gb_pixel_fifo_if.slave bus
);
    localparam int            AW        = $clog2(DEPTH);
    localparam int            XW        = $clog2(LINE_PIX);
    localparam logic [AW:0]   READY_MAX = (AW+1)'(DEPTH - GROUP_PIX);
    localparam logic [XW-1:0] X_LAST    = XW'(LINE_PIX - 1);

    pix_state_e       state;
    pix_state_e       state_nxt;
    logic [2:0]       disc;
    logic [XW-1:0]    x;
    logic [AW:0]      count;
    logic [PIX_W-1:0] rd_pix;
    logic             can_pop;
    logic             pop_disc;
    logic             pop_run;
    logic             fifo_clear;
    logic             do_push;
    logic             push_ready;
    logic [PIX_W-1:0] lcd_data_p1;
    logic             vld_p1;
    logic             line_done_p1;
    logic             busy_p1;

    gb_pixel_fifo_mem #(.PIX_W(PIX_W), .DEPTH(DEPTH)) u_mem (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clear   (fifo_clear),
        .wr_en   (do_push),
        .wr_pix  (bus.push_pix),
        .rd_en   (pop_disc | pop_run),
        .rd_pix  (rd_pix),
        .count   (count)
    );

    // State register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state; line_start restarts the line from any state.
    always_comb begin
        state_nxt = state;
        if (bus.line_start) begin
            state_nxt = ST_DISCARD;
        end else begin
            case (state)
                ST_DISCARD: if (disc == 3'd0) state_nxt = ST_RUN;
                ST_RUN:     if (pop_run && x == X_LAST) state_nxt = ST_DONE;
                ST_DONE:    state_nxt = ST_IDLE;
                default:    ;
            endcase
        end
    end

    // Per-state control strobes: pop, push acceptance and FIFO clear.
    always_comb begin
        can_pop    = ce_cpu && !bus.stall && (count != '0);
        pop_disc   = 1'b0;
        pop_run    = 1'b0;
        push_ready = 1'b0;
        fifo_clear = bus.line_start;
        case (state)
            ST_DISCARD: begin
                push_ready = (count <= READY_MAX);
                pop_disc   = can_pop && (disc != 3'd0) && !bus.line_start;
            end
            ST_RUN: begin
                push_ready = (count <= READY_MAX);
                pop_run    = can_pop && !bus.line_start;
            end
            ST_DONE:  fifo_clear = 1'b1;
            default:  ;
        endcase
        do_push = bus.push && push_ready && !bus.line_start;
    end

    // Line counters: remaining pixels to drop and emitted-pixel position.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            disc <= '0;
            x    <= '0;
        end else if (bus.line_start) begin
            disc <= bus.scx_fine;
            x    <= '0;
        end else begin
            if (pop_disc) disc <= disc - 3'd1;
            if (pop_run)  x    <= x + XW'(1);
        end
    end

    // Output stage: registered pixel strobe, end-of-line pulse and busy flag.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            lcd_data_p1  <= '0;
            vld_p1       <= 1'b0;
            line_done_p1 <= 1'b0;
            busy_p1      <= 1'b0;
        end else begin
            vld_p1       <= pop_run;
            line_done_p1 <= (state == ST_DONE) && !bus.line_start;
            if (pop_run) lcd_data_p1 <= rd_pix;
            if (bus.line_start)       busy_p1 <= 1'b1;
            else if (state == ST_DONE) busy_p1 <= 1'b0;
        end
    end

`ifdef GB_PIXFIFO_STATS_EN
    // Saturating count of pixel slots lost to an empty FIFO while emitting.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            underflow_cnt <= '0;
        end else if (state == ST_RUN && ce_cpu && !bus.stall && count == '0 &&
                     !bus.line_start && underflow_cnt != 16'hFFFF) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`endif

    assign bus.push_ready = push_ready;
    assign bus.lcd_data   = lcd_data_p1;
    assign bus.lcd_clkena = vld_p1;
    assign bus.line_done  = line_done_p1;
    assign bus.busy       = busy_p1;

endmodule

// File: tb/tb_gb_pixel_fifo.sv
// tb_gb_pixel_fifo: randomized fetcher/stall stimulus against a queue-based line model.
module tb_gb_pixel_fifo;
    localparam int PW       = 15;
    localparam int DEPTH    = 16;
    localparam int LINE_PIX = 160;

    logic clk_sys = 1'b0;
    logic reset;
    logic ce_cpu;

    gb_pixel_fifo_if #(.PIX_W(PW)) bus();
`ifdef GB_PIXFIFO_STATS_EN
    logic [15:0] underflow_cnt;
`endif

    gb_pixel_fifo #(.PIX_W(PW), .DEPTH(DEPTH), .LINE_PIX(LINE_PIX)) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ce_cpu        (ce_cpu),
`ifdef GB_PIXFIFO_STATS_EN
        .underflow_cnt (underflow_cnt),
`endif
        .bus           (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk_sys) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 dropping leading pixels, 2 emitting, 3 finishing
    logic [PW-1:0] mq[$];
    int            phase, to_drop, m_emit, m_uf;
    logic          m_clk, m_done, m_busy;
    logic [PW-1:0] m_data;

    function automatic void model_reset();
        mq.delete();
        phase = 0; to_drop = 0; m_emit = 0; m_uf = 0;
        m_clk = 0; m_done = 0; m_busy = 0; m_data = '0;
    endfunction

    function automatic bit model_ready();
        return (mq.size() <= DEPTH - 8) && (phase == 1 || phase == 2);
    endfunction

    task automatic model_step();
        bit pr, can_pop;
        pr      = model_ready();
        can_pop = ce_cpu && !bus.stall && (mq.size() != 0);
        m_clk   = 0;
        m_done  = 0;
        if (bus.line_start) begin
            mq.delete();
            phase = 1; to_drop = int'(bus.scx_fine); m_emit = 0; m_busy = 1;
        end else begin
            case (phase)
                1: if (to_drop == 0) phase = 2;
                   else if (can_pop) begin mq.delete(0); to_drop--; end
                2: if (can_pop) begin
                       m_data = mq.pop_front(); m_clk = 1; m_emit++;
                       if (m_emit == LINE_PIX) phase = 3;
                   end else if (ce_cpu && !bus.stall && m_uf < 65535) m_uf++;
                3: begin m_done = 1; m_busy = 0; mq.delete(); phase = 0; end
                default: ;
            endcase
            if (bus.push && pr)
                for (int i = 0; i < 8; i++) mq.push_back(bus.push_pix[i*PW +: PW]);
        end
    endtask

    always @(posedge clk_sys) begin
        if (reset) model_reset();
        else       model_step();
    end

    // ---------------- compare + observation ----------------
    logic [PW-1:0] emitted_q[$];
    int done_cnt = 0, done_cyc = 0, last_clk_cyc = 0;

    always @(negedge clk_sys) begin
        if (chk_en) begin
            check("lcd_clkena", bus.lcd_clkena, m_clk);
            if (m_clk) check("lcd_data", bus.lcd_data, m_data);
            check("line_done", bus.line_done, m_done);
            check("busy", bus.busy, m_busy);
            check("push_ready", bus.push_ready, model_ready());
`ifdef GB_PIXFIFO_STATS_EN
            check("underflow_cnt", underflow_cnt, m_uf);
`endif
        end
        if (bus.lcd_clkena) begin emitted_q.push_back(bus.lcd_data); last_clk_cyc = cyc; end
        if (bus.line_done)  begin done_cnt++; done_cyc = cyc; end
    end

    // ---------------- stimulus ----------------
    int push_pct, stall_pct, junk_pct, groups_left, next_pix, ce_ph;
    bit force_stall;

    task automatic drive_cycle(input bit ls, input logic [2:0] scx);
        ce_ph          = (ce_ph + 1) % 4;
        ce_cpu         = (ce_ph == 0);
        bus.line_start = ls;
        bus.scx_fine   = scx;
        bus.push       = 1'b0;
        if (!ls && bus.push_ready && groups_left != 0 && $urandom_range(0, 99) < push_pct) begin
            bus.push = 1'b1;
            for (int i = 0; i < 8; i++) bus.push_pix[i*PW +: PW] = PW'(next_pix + i);
            next_pix += 8;
            if (groups_left > 0) groups_left--;
        end else if (!bus.push_ready && $urandom_range(0, 99) < junk_pct) begin
            bus.push = 1'b1;
            for (int i = 0; i < 8; i++) bus.push_pix[i*PW +: PW] = PW'($urandom());
        end
        bus.stall = force_stall || ($urandom_range(0, 99) < stall_pct);
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_line(input logic [2:0] scx);
        emitted_q.delete();
        next_pix = 0;
        drive_cycle(1'b1, scx);
    endtask

    task automatic run_until_done(input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin drive_cycle(1'b0, 3'd0); n++; end
        check("line_done_seen", done_cnt != d0, 1);
        drive_cycle(1'b0, 3'd0);
        drive_cycle(1'b0, 3'd0);
        check("busy_after_line", bus.busy, 0);
    endtask

    task automatic run_until_got(input int want, input int budget);
        int n = 0;
        while (emitted_q.size() < want && n < budget) begin drive_cycle(1'b0, 3'd0); n++; end
        check("reach_pixel_count", emitted_q.size() >= want, 1);
    endtask

    task automatic wait_ce(input int k);
        int seen = 0;
        int n    = 0;
        while (seen < k && n < 1000) begin
            drive_cycle(1'b0, 3'd0);
            if (ce_cpu) seen++;
            n++;
        end
    endtask

    task automatic check_line(input string tag, input int base);
        bit ok = 1'b1;
        check({tag, "_count"}, emitted_q.size(), LINE_PIX);
        foreach (emitted_q[i]) if (emitted_q[i] != PW'(base + i)) ok = 1'b0;
        check({tag, "_order"}, ok, 1);
        check({tag, "_first"}, emitted_q.size() > 0 ? 32'(emitted_q[0]) : 32'hFFFF_FFFF, base);
        check({tag, "_done_lag"}, done_cyc - last_clk_cyc, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_clkena"}, bus.lcd_clkena, 0);
        check({tag, "_data"}, bus.lcd_data, 0);
        check({tag, "_line_done"}, bus.line_done, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_push_ready"}, bus.push_ready, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sz, uf0, d0;
        logic [2:0] scx;
`ifdef GB_PIXFIFO_STATS_EN
        logic [15:0] dut_uf0;
`endif
        reset = 1'b1; ce_cpu = 1'b0; force_stall = 1'b0;
        bus.line_start = 1'b0; bus.scx_fine = '0; bus.push = 1'b0;
        bus.push_pix = '0; bus.stall = 1'b0;
        push_pct = 100; stall_pct = 0; junk_pct = 0; groups_left = -1; next_pix = 0; ce_ph = 0;
        model_reset();
        chk_en = 1'b1;
        #2;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk_sys);
        #1;
        reset = 1'b0;

        // scx 0, unblocked fetcher: pixels 0..159
        start_line(3'd0);
        run_until_done(3000);
        check_line("scx0", 0);

        // scx 5: first five dropped, pixels 5..164
        start_line(3'd5);
        run_until_done(3000);
        check_line("scx5", 5);

        // sprite stall for six pixel slots mid-line
        start_line(3'd0);
        run_until_got(40, 2000);
        sz = emitted_q.size();
        force_stall = 1'b1;
        wait_ce(6);
        check("stall_no_clkena", emitted_q.size(), sz);
        check("stall_push_ready_low", bus.push_ready, 0);
        force_stall = 1'b0;
        run_until_done(3000);
        check_line("stall", 0);

        // fetcher starves after one group
        groups_left = 1;
        start_line(3'd0);
        run_until_got(8, 1000);
        uf0 = m_uf;
`ifdef GB_PIXFIFO_STATS_EN
        dut_uf0 = underflow_cnt;
`endif
        wait_ce(3);
        check("starve_clkena", emitted_q.size(), 8);
        check("starve_x_model", m_emit, 8);
        check("starve_uf_model", m_uf - uf0, 3);
`ifdef GB_PIXFIFO_STATS_EN
        check("starve_uf_dut", underflow_cnt - dut_uf0, 3);
`endif
        groups_left = -1;
        run_until_done(3000);
        check_line("starve", 0);

        // mid-line restart at x=40
        start_line(3'd3);
        run_until_got(40, 2000);
        d0 = done_cnt;
        start_line(3'd0);
        run_until_done(3000);
        check("restart_one_done", done_cnt - d0, 1);
        check_line("restart", 0);

        // randomized lines
        for (int l = 0; l < 4; l++) begin
            push_pct  = $urandom_range(30, 100);
            stall_pct = $urandom_range(0, 25);
            junk_pct  = 15;
            scx       = 3'($urandom_range(0, 7));
            start_line(scx);
            run_until_done(20000);
            check_line("rand", int'(scx));
        end

        // asynchronous reset at x=100
        push_pct = 100; stall_pct = 0; junk_pct = 0;
        start_line(3'd2);
        run_until_got(100, 2000);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs_zero("async_reset");
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        sz = emitted_q.size();
        junk_pct = 100;
        repeat (40) drive_cycle(1'b0, 3'd0);
        check("post_reset_no_clkena", emitted_q.size(), sz);
        check("post_reset_busy", bus.busy, 0);
        check("post_reset_ready", bus.push_ready, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
